// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - shared constants and FSM encoding for the FPMul arbiter
//
// Purpose: flag vector width, flag bit positions and the 2-bit arbiter state
//          encoding shared by fpmul_arbiter and its bench.
package fpmul_pkg;

  localparam int FLAG_W    = 6;

  // Bit positions inside {OF,UF,NANF,INFF,DNF,ZF}
  localparam int FLAG_OF   = 5;
  localparam int FLAG_UF   = 4;
  localparam int FLAG_NANF = 3;
  localparam int FLAG_INFF = 2;
  localparam int FLAG_DNF  = 1;
  localparam int FLAG_ZF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
//
// Purpose: selects the first active request at or above the pointer,
//          wrapping around to index 0.
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [IDW-1:0]   round-robin start position
//   gnt_o  [NREQ-1:0]  one-hot grant (all zero when no request)
//   idx_o  [IDW-1:0]   binary index of the grant
//   any_o              at least one request is active
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] idx_hi, idx_lo;
  logic           any_hi, any_lo;

  // Scan downwards so the last hit is the lowest index: idx_hi is the lowest
  // request at or above the pointer, idx_lo the lowest overall (the wrap case).
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        idx_lo = IDW'(j);
        any_lo = 1'b1;
        if (j >= int'(ptr_i)) begin
          idx_hi = IDW'(j);
          any_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_o = any_lo;
    idx_o = any_hi ? idx_hi : idx_lo;
    gnt_o = any_lo ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - round-robin sharing of one FPMul core among NREQ requesters
//
// Purpose: grants one requester at a time, issues a single start pulse to the
//          multiplier, waits for done and returns product/flags with a
//          one-cycle ack. Optional watchdog enabled by macro FPMUL_TIMEOUT_EN.
// Ports:
//   clk, rst (sync, active-low)
//   req/req_a/req_b      requester side: request and packed 32-bit operands
//   ack/res_p/res_flags/res_err  per-operation response
//   busy/gnt_id          status
//   mul_start/mul_a/mul_b/mul_done/mul_p/mul_flags  FPMul core side
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          res_p,
  output logic [FLAG_W-1:0]    res_flags,
  output logic                 res_err,
  output logic                 busy,
  output logic [IDW-1:0]       gnt_id,
  output logic                 mul_start,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic                 mul_done,
  input  logic [31:0]          mul_p,
  input  logic [FLAG_W-1:0]    mul_flags
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0]       res_p_q, res_p_d;
  logic [FLAG_W-1:0] res_flags_q, res_flags_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDW-1:0]    arb_idx;
  logic              arb_any;
  logic [31:0]       sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // One-hot grant drives an AND-OR operand mux
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

`ifdef FPMUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          res_err_q, res_err_d;
`else
  // Watchdog limit is meaningless without the watchdog
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_id_d    = gnt_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_p_d     = res_p_q;
    res_flags_d = res_flags_q;
`ifdef FPMUL_TIMEOUT_EN
    wd_d        = wd_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_id_d = arb_idx;
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef FPMUL_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (mul_done) begin
          res_p_d     = mul_p;
          res_flags_d = mul_flags;
`ifdef FPMUL_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef FPMUL_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          res_p_d     = '0;
          res_flags_d = '0;
          res_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rr_d    = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      gnt_id_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_p_q     <= '0;
      res_flags_q <= '0;
`ifdef FPMUL_TIMEOUT_EN
      wd_q        <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_id_q    <= gnt_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_p_q     <= res_p_d;
      res_flags_q <= res_flags_d;
`ifdef FPMUL_TIMEOUT_EN
      wd_q        <= wd_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

`ifdef FPMUL_TIMEOUT_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign ack       = (state_q == ST_RESP) ? (NREQ'(1) << gnt_id_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign mul_start = (state_q == ST_ISSUE);
  assign gnt_id    = gnt_id_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_p     = res_p_q;
  assign res_flags = res_flags_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb/tb_fpmul_arbiter.sv - directed self-checking bench for fpmul_arbiter
module tb_fpmul_arbiter;
  import fpmul_pkg::*;

  localparam int NREQ    = 3;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 4;
  localparam int LIMIT   = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   ack;
  logic [31:0]       res_p;
  logic [FLAG_W-1:0] res_flags;
  logic              res_err;
  logic              busy;
  logic [IDW-1:0]    gnt_id;
  logic              mul_start;
  logic [31:0]       mul_a, mul_b;
  logic              mul_done;
  logic [31:0]       mul_p;
  logic [FLAG_W-1:0] mul_flags;

  int n_chk  = 0;
  int n_fail = 0;

  fpmul_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .ack       (ack),
    .res_p     (res_p),
    .res_flags (res_flags),
    .res_err   (res_err),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .mul_flags (mul_flags)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: two real IEEE cases, otherwise a XOR signature that
  // proves the right operands reached the core.
  function automatic logic [37:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {6'b000000, 32'h4000_0000};
    if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {6'b001000, 32'h7FC0_0000};
    return {6'b000000, a ^ b};
  endfunction

  assign {mul_flags, mul_p} = fmodel(mul_a, mul_b);

  logic m_en   = 1'b1;
  logic spur   = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;

  // done arrives LAT cycles after the cycle mul_start is high
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (mul_start && m_en) m_cnt <= LAT - 1;
    else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  assign mul_done = m_done | spur;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst  = 1'b0;
    req  = '0;
    spur = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Holds req=r until an ack appears; spur_at>=0 pulses mul_done that many
  // cycles after the start pulse. Cycle numbers count edges from the call.
  task automatic run_op(input logic [NREQ-1:0] r, input int spur_at,
                        output logic [NREQ-1:0] a_seen, output int c_start, output int c_ack);
    req     = r;
    c_start = -1;
    c_ack   = -1;
    a_seen  = '0;
    for (int c = 1; c <= LIMIT; c++) begin
      @(posedge clk);
      #1;
      if (mul_start && c_start < 0) c_start = c;
      spur = (spur_at >= 0 && c_start >= 0 && c == c_start + spur_at);
      if (|ack) begin
        a_seen = ack;
        c_ack  = c;
        break;
      end
    end
    spur = 1'b0;
  endtask

  logic [NREQ-1:0] rr_ack_e [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
  logic [IDW-1:0]  rr_id_e  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
  logic [31:0]     rr_p_e   [6] = '{32'h1111_FFFF, 32'h2222_3333, 32'h4444_5555,
                                    32'h1111_FFFF, 32'h4444_5555, 32'h1111_FFFF};

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 200000, 0);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] a_seen;
    int c_s, c_a, n_ack, n_busy;
    logic found;

    rst = 1'b0; req = '0; req_a = '0; req_b = '0;
    apply_reset();

    // Reset state
    check_eq("rst_ack",       64'(ack),       64'(0));
    check_eq("rst_busy",      64'(busy),      64'(0));
    check_eq("rst_gnt_id",    64'(gnt_id),    64'(0));
    check_eq("rst_mul_start", 64'(mul_start), 64'(0));
    check_eq("rst_mul_ab",    {mul_a, mul_b}, 64'(0));
    check_eq("rst_res",       {res_p, 26'd0, res_flags}, 64'(0));
    check_eq("rst_res_err",   64'(res_err),   64'(0));

    // Single request: 1.0 * 2.0, latency start@1, ack@6
    set_ops(0, 32'h3F80_0000, 32'h4000_0000);
    run_op(3'b001, -1, a_seen, c_s, c_a);
    req = '0;
    check_eq("t1_start_cyc", 64'(c_s),       64'(1));
    check_eq("t1_ack_cyc",   64'(c_a),       64'(6));
    check_eq("t1_ack",       64'(a_seen),    64'(3'b001));
    check_eq("t1_res_p",     64'(res_p),     64'h4000_0000);
    check_eq("t1_res_flags", 64'(res_flags), 64'(0));
    check_eq("t1_res_err",   64'(res_err),   64'(0));
    n_ack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (|ack) n_ack++;
    end
    check_eq("t1_extra_ack", 64'(n_ack),   64'(0));
    check_eq("t1_hold_p",    64'(res_p),   64'h4000_0000);
    check_eq("t1_mul_a",     64'(mul_a),   64'h3F80_0000);
    check_eq("t1_idle",      64'(busy),    64'(0));

    // Round-robin: 111 for three ops, then 101 for three ops
    apply_reset();
    set_ops(0, 32'h1111_0000, 32'h0000_FFFF);
    set_ops(1, 32'h2222_0000, 32'h0000_3333);
    set_ops(2, 32'h4444_0000, 32'h0000_5555);
    for (int k = 0; k < 6; k++) begin
      run_op((k < 3) ? 3'b111 : 3'b101, -1, a_seen, c_s, c_a);
      check_eq($sformatf("rr%0d_ack", k),    64'(a_seen), 64'(rr_ack_e[k]));
      check_eq($sformatf("rr%0d_gnt_id", k), 64'(gnt_id), 64'(rr_id_e[k]));
      check_eq($sformatf("rr%0d_res_p", k),  64'(res_p),  64'(rr_p_e[k]));
    end
    req = '0;
    @(posedge clk); #1;

    // Flags pass-through: inf * 0 on requester 1
    set_ops(1, 32'h7F80_0000, 32'h0000_0000);
    run_op(3'b010, -1, a_seen, c_s, c_a);
    req = '0;
    check_eq("fl_ack",       64'(a_seen),    64'(3'b010));
    check_eq("fl_gnt_id",    64'(gnt_id),    64'(1));
    check_eq("fl_res_p",     64'(res_p),     64'h7FC0_0000);
    check_eq("fl_res_flags", 64'(res_flags), 64'(6'b001000));
    @(posedge clk); #1;

    // Spurious done in IDLE and ISSUE
    m_en = 1'b0;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check_eq("sp_idle_busy", 64'(busy), 64'(0));
    check_eq("sp_idle_ack",  64'(ack),  64'(0));
    req = 3'b001;
    @(posedge clk); #1;
    check_eq("sp_issue", 64'(mul_start), 64'(1));
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check_eq("sp_wait_busy", 64'(busy), 64'(1));
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (|ack) n_ack++;
    end
    check_eq("sp_early_ack", 64'(n_ack), 64'(0));
    spur = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      spur = 1'b0;
      if (|ack) begin
        n_ack++;
        req = '0;
        check_eq("sp_res_p", 64'(res_p), 64'h1111_FFFF);
      end
    end
    check_eq("sp_ack_count", 64'(n_ack), 64'(1));

    // Reset in the middle of WAIT on requester 1
    m_en = 1'b1;
    req = 3'b010;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (mul_start) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mr_started", 64'(found), 64'(1));
    @(posedge clk); #1;
    check_eq("mr_in_wait", 64'(busy), 64'(1));
    rst = 1'b0;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("mr_busy",    64'(busy),   64'(0));
    check_eq("mr_gnt_id",  64'(gnt_id), 64'(0));
    check_eq("mr_mul_ab",  {mul_a, mul_b}, 64'(0));
    check_eq("mr_res",     {res_p, 26'd0, res_flags}, 64'(0));
    check_eq("mr_res_err", 64'(res_err), 64'(0));
    n_ack = 0;
    n_busy = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (|ack) n_ack++;
      if (busy) n_busy++;
    end
    check_eq("mr_late_ack",  64'(n_ack),  64'(0));
    check_eq("mr_late_busy", 64'(n_busy), 64'(0));
    run_op(3'b111, -1, a_seen, c_s, c_a);
    req = '0;
    check_eq("mr_next_ack", 64'(a_seen), 64'(3'b001));
    check_eq("mr_next_id",  64'(gnt_id), 64'(0));
    @(posedge clk); #1;

    m_en = 1'b0;
`ifdef FPMUL_TIMEOUT_EN
    // Watchdog expiry: ack 9 cycles after the start pulse
    run_op(3'b001, -1, a_seen, c_s, c_a);
    req = '0;
    check_eq("to_ack",       64'(a_seen),      64'(3'b001));
    check_eq("to_delay",     64'(c_a - c_s),   64'(TIMEOUT + 1));
    check_eq("to_res_err",   64'(res_err),     64'(1));
    check_eq("to_res_p",     64'(res_p),       64'(0));
    check_eq("to_res_flags", 64'(res_flags),   64'(0));
    @(posedge clk); #1;
`endif
    // done on the 8th WAIT cycle: normal completion
    run_op(3'b001, TIMEOUT, a_seen, c_s, c_a);
    req = '0;
    check_eq("d8_ack",     64'(a_seen),    64'(3'b001));
    check_eq("d8_delay",   64'(c_a - c_s), 64'(TIMEOUT + 1));
    check_eq("d8_res_err", 64'(res_err),   64'(0));
    check_eq("d8_res_p",   64'(res_p),     64'h1111_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
Shares one FPMul multiplier core among NREQ requesters, e.g. CPU wrapper port, DMA engine and a vector sequencer.
- Round-robin request/grant.
- Registers the winner's operands and issues exactly one start pulse per operation.
- Waits for done, then returns product and flags to the winner with a one-cycle ack.
- Sits between the requester ports and the single FPMul instance.

Parameters:
NREQ, 3, number of requesters (2..8)
IDW, 2, width of grant index; must satisfy 2**IDW >= NREQ
TIMEOUT, 64, watchdog limit in cycles (used only with FPMUL_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-low
req  input  NREQ  request per requester; held high until its ack
req_a  input  NREQ*32  operand A per requester; slice i is bits [32i+31:32i]
req_b  input  NREQ*32  operand B per requester, same packing
ack  output  NREQ  one-hot one-cycle completion pulse
res_p  output  32  product of the acked operation
res_flags  output  6  {OF,UF,NANF,INFF,DNF,ZF} of the acked operation
res_err  output  1  timeout error for the acked operation (0 when feature off)
busy  output  1  high in every state except IDLE
gnt_id  output  IDW  index of current or last granted requester
mul_start  output  1  one-cycle start pulse to FPMul
mul_a  output  32  operand A to FPMul
mul_b  output  32  operand B to FPMul
mul_done  input  1  FPMul done
mul_p  input  32  FPMul product
mul_flags  input  6  FPMul flags, same order as res_flags

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, rr pointer=0.
- On reset, these outputs are 0: ack, res_p, res_flags, res_err, busy, gnt_id, mul_start, mul_a, mul_b.
- Reset mid-operation aborts silently: no ack. Any later mul_done is ignored until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req is high:
  - Pick the first requester at or above the rr pointer, with wrap-around.
  - Latch its index into gnt_id.
  - Latch its operands into mul_a/mul_b.
  - Go to ISSUE.
- IDLE, when no req is high: stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
- mul_a/mul_b stay stable from ISSUE until the state leaves RESP.
- WAIT, on mul_done==1:
  - Register mul_p and mul_flags into res_p and res_flags.
  - Go to RESP.
- RESP:
  - ack[gnt_id]=1 for exactly one cycle.
  - rr pointer = gnt_id+1, wrapping to 0 after NREQ-1.
  - Return to IDLE.
- res_p, res_flags and res_err hold their value until the next RESP.
- mul_done seen in IDLE, ISSUE or RESP is ignored.
- Latency: req sampled in IDLE at cycle 0 → mul_start at cycle 1 → mul_done at cycle 1+L → ack at cycle 2+L.
- A new grant is possible in the cycle after RESP, so there is a one-cycle IDLE bubble between operations.
- A requester may not drop req before its ack. If it does, the operation still completes and ack is still pulsed.
- Requests arriving while busy are queued only by virtue of req being held. No other buffering.
- With a single requester asserting continuously, it is regranted every operation.

Optional Feature:
Macro FPMUL_TIMEOUT_EN.
- When defined:
  - A counter clears on ISSUE and increments in WAIT.
  - If it reaches TIMEOUT without mul_done: go to RESP with res_err=1, res_p=0, res_flags=0.
  - A mul_done in the same cycle the counter hits TIMEOUT wins: normal result, res_err=0.
- When undefined: no counter, res_err tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package fpmul_pkg holds:
  - FLAG_W=6.
  - Flag bit indices: OF=5, UF=4, NANF=3, INFF=2, DNF=1, ZF=0.
  - 2-bit state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- Sub-module rr_arbiter (combinational): req vector + pointer → one-hot grant + index.
- FSM, operand/result registers and watchdog stay in fpmul_arbiter.

Test Plan:
- Single request: req[0]=1, A=0x3F800000, B=0x40000000, FPMul model with L=4 → mul_start at cycle 1; ack[0] at cycle 6; res_p=0x40000000, res_flags=0.
- Round-robin: req=3'b111 held through 3 operations → grants 0,1,2, each ack one-hot. Then req=3'b101 → grants 0,2,0.
- Flags pass-through: A=0x7F800000, B=0x00000000 → res_p=0x7FC00000, res_flags=6'b001000 (NANF), ack to the correct requester.
- Spurious done: pulse mul_done in IDLE and in ISSUE → no state change, no ack; exactly one ack after the real done.
- Reset mid-WAIT: rst=0 for one cycle, then the model asserts done → no ack, busy=0, all outputs 0, next grant starts from requester 0.
- FPMUL_TIMEOUT_EN, TIMEOUT=8, model never asserts done → ack at 8 WAIT cycles after ISSUE with res_err=1, res_p=0. Second case: done on the 8th cycle → res_err=0.
